// File: rtl/gcd4_issue_if.sv
// Operand/result bundle between the GCD issue stage and its surroundings.
// Both in_* and res_* are valid/ready: a transfer happens on a rising edge where valid && ready; a source holding valid keeps its data stable until that edge.
interface gcd4_issue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_a;
    logic [3:0]    in_b;
    logic [3:0]    gcd_a;
    logic [3:0]    gcd_b;
    logic [3:0]    gcd_out;
    logic          res_valid;
    logic          res_ready;
    logic [3:0]    res_a;
    logic [3:0]    res_b;
    logic [3:0]    res_gcd;
    logic [CW-1:0] count;
    logic          busy;
    logic [1:0]    dbg_state;

    modport slave (
        input  in_valid, in_a, in_b, gcd_out, res_ready,
        output in_ready, gcd_a, gcd_b, res_valid, res_a, res_b, res_gcd, count, busy, dbg_state
    );

    modport master (
        output in_valid, in_a, in_b, gcd_out, res_ready,
        input  in_ready, gcd_a, gcd_b, res_valid, res_a, res_b, res_gcd, count, busy, dbg_state
    );
endinterface

// File: rtl/gcd4_issue.sv
// Operand FIFO and issue FSM in front of a 4-bit GCD unit; zero operands are
// resolved locally as a|b without touching the unit.
module gcd4_issue #(
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    gcd4_issue_if.slave io
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_gcd_a;
    logic [3:0]    r_gcd_b;
    logic [3:0]    r_res_a;
    logic [3:0]    r_res_b;
    logic [3:0]    r_res_gcd;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [3:0]    w_head_a;
    logic [3:0]    w_head_b;
    logic          w_head_zero;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = io.in_valid && !w_full;
    assign w_head_a    = r_mem[r_rd_ptr][7:4];
    assign w_head_b    = r_mem[r_rd_ptr][3:0];
    assign w_head_zero = (w_head_a == 4'd0) || (w_head_b == 4'd0);

    always_comb begin
        w_pop        = 1'b0;
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = w_head_zero ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  w_next_state = S_DONE;
            S_DONE: begin
                if (io.res_ready) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = w_head_zero ? S_DONE : S_ISSUE;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {io.in_a, io.in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_gcd_a   <= 4'd0;
            r_gcd_b   <= 4'd0;
            r_res_a   <= 4'd0;
            r_res_b   <= 4'd0;
            r_res_gcd <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // The operand lines double as the held operands for the result.
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_gcd_a  <= w_head_a;
                r_gcd_b  <= w_head_b;
                if (w_head_zero) begin
                    r_res_a   <= w_head_a;
                    r_res_b   <= w_head_b;
                    r_res_gcd <= w_head_a | w_head_b;
                end
            end
            if (r_state == S_WAIT) begin
                r_res_a   <= r_gcd_a;
                r_res_b   <= r_gcd_b;
                r_res_gcd <= io.gcd_out;
            end
        end
    end

    assign io.in_ready  = !w_full;
    assign io.gcd_a     = r_gcd_a;
    assign io.gcd_b     = r_gcd_b;
    assign io.res_valid = (r_state == S_DONE);
    assign io.res_a     = r_res_a;
    assign io.res_b     = r_res_b;
    assign io.res_gcd   = r_res_gcd;
    assign io.count     = r_count;
    assign io.busy      = (r_state != S_IDLE);
    assign io.dbg_state = r_state;
endmodule

// File: tb/tb_gcd4_issue.sv
// Self-checking bench for gcd4_issue with a behavioural registered GCD unit
// and a scoreboard of {a, b, gcd} expected in issue order.
module tb_gcd4_issue;
    logic clk;
    logic rst;
    logic force_f;
    logic stream_chk;
    int   cyc;
    int   last_cyc;
    int   n_checks;
    int   n_fail;
    logic [11:0] exp_q[$];

    gcd4_issue_if #(.DEPTH(4)) ifc ();

    gcd4_issue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference GCD unit ----------------
    function automatic logic [3:0] gcd_fn(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] t;
        x = a;
        y = b;
        while (y != 4'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        ifc.gcd_out <= force_f ? 4'hF : gcd_fn(ifc.gcd_a, ifc.gcd_b);
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks (drive 1 time unit after posedge) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
        int n;
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_valid = 1'b1;
        n = 0;
        while (!ifc.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            check_val("push_timeout", 32'(ifc.in_ready), 32'd1);
        end else begin
            exp_q.push_back({a, b, gcd_fn(a, b)});
            tick();
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ifc.busy) && n < 300) begin
            tick();
            n++;
        end
        check_val("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard monitor (negedge) ----------------
    logic        cnt_pending;
    logic [2:0]  cnt_saved;

    always @(negedge clk) begin
        if (rst) begin
            cnt_pending = 1'b0;
        end else begin
            if (cnt_pending) begin
                check_val("cnt_push_pop", 32'(ifc.count), 32'(cnt_saved));
            end
            cnt_pending = ifc.in_valid && ifc.in_ready && (ifc.count != 0) &&
                          ((ifc.res_valid && ifc.res_ready) || !ifc.busy);
            cnt_saved   = ifc.count;
            if (ifc.res_valid && ifc.res_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("res_unexpected", 32'(ifc.res_valid), 32'd0);
                end else begin
                    check_val("result", {20'd0, ifc.res_a, ifc.res_b, ifc.res_gcd},
                              {20'd0, exp_q.pop_front()});
                end
                if (stream_chk) begin
                    if (last_cyc >= 0) begin
                        check_val("stream_gap", 32'(cyc - last_cyc), 32'd3);
                    end
                    last_cyc = cyc;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic stale_seen;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        cyc          = 0;
        last_cyc     = -1;
        stream_chk   = 1'b0;
        force_f      = 1'b0;
        rst          = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_a     = 4'd0;
        ifc.in_b     = 4'd0;
        ifc.res_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check_val("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        check_val("rst_count", 32'(ifc.count), 32'd0);
        check_val("rst_res_valid", 32'(ifc.res_valid), 32'd0);
        check_val("rst_busy", 32'(ifc.busy), 32'd0);
        check_val("rst_gcd_ab", {24'd0, ifc.gcd_a, ifc.gcd_b}, 32'd0);

        // Single nonzero pair: push at p, operands after p+1, res_valid after p+3
        push_pair(4'd12, 4'd8);
        check_val("p0_res_valid", 32'(ifc.res_valid), 32'd0);
        tick();
        check_val("p1_gcd_ab", {24'd0, ifc.gcd_a, ifc.gcd_b}, {24'd0, 4'd12, 4'd8});
        check_val("p1_state", 32'(ifc.dbg_state), 32'd1);
        tick();
        check_val("p2_res_valid", 32'(ifc.res_valid), 32'd0);
        tick();
        check_val("p3_res_valid", 32'(ifc.res_valid), 32'd1);
        check_val("p3_res", {20'd0, ifc.res_a, ifc.res_b, ifc.res_gcd},
                  {20'd0, 4'd12, 4'd8, 4'd4});
        wait_drain();

        // Zero operands: gcd_out forced to F must be ignored
        force_f = 1'b1;
        push_pair(4'd5, 4'd0);
        check_val("z0_res_valid", 32'(ifc.res_valid), 32'd0);
        tick();
        check_val("z1_res_valid", 32'(ifc.res_valid), 32'd1);
        check_val("z1_res_gcd", 32'(ifc.res_gcd), 32'd5);
        wait_drain();
        push_pair(4'd0, 4'd9);
        push_pair(4'd7, 4'd0);
        push_pair(4'd0, 4'd0);
        wait_drain();
        force_f = 1'b0;

        // Backpressure and full FIFO
        ifc.res_ready = 1'b0;
        push_pair(4'd15, 4'd10);
        push_pair(4'd9, 4'd6);
        push_pair(4'd14, 4'd7);
        push_pair(4'd13, 4'd5);
        push_pair(4'd8, 4'd4);
        check_val("full_count", 32'(ifc.count), 32'd4);
        check_val("full_in_ready", 32'(ifc.in_ready), 32'd0);
        check_val("bp_res_gcd", 32'(ifc.res_gcd), 32'd5);
        fork
            push_pair(4'd6, 4'd6);
            begin
                repeat (3) tick();
                check_val("bp_refused", 32'(ifc.in_ready), 32'd0);
                check_val("bp_hold", {20'd0, ifc.res_a, ifc.res_b, ifc.res_gcd},
                          {20'd0, 4'd15, 4'd10, 4'd5});
                ifc.res_ready = 1'b1;
            end
        join
        wait_drain();

        // Streaming: 12 random nonzero pairs, one result every 3 cycles
        last_cyc   = -1;
        stream_chk = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push_pair(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
        end
        wait_drain();
        stream_chk = 1'b0;

        // Reset in WAIT with 2 pairs buffered
        ifc.res_ready = 1'b0;
        push_pair(4'd9, 4'd3);
        push_pair(4'd12, 4'd9);
        push_pair(4'd10, 4'd5);
        check_val("mid_state_wait", 32'(ifc.dbg_state), 32'd2);
        check_val("mid_count", 32'(ifc.count), 32'd2);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        ifc.res_ready = 1'b1;
        check_val("mr_res_valid", 32'(ifc.res_valid), 32'd0);
        check_val("mr_count", 32'(ifc.count), 32'd0);
        check_val("mr_busy", 32'(ifc.busy), 32'd0);
        check_val("mr_gcd_ab", {24'd0, ifc.gcd_a, ifc.gcd_b}, 32'd0);
        stale_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ifc.res_valid) stale_seen = 1'b1;
        end
        check_val("mr_no_stale", 32'(stale_seen), 32'd0);
        push_pair(4'd10, 4'd4);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
